queue8_ctrl: RTL and testbench
==============================

Name: queue8_ctrl

Overview:
- 8-entry circular FIFO with 3-bit read/write pointers, each extended by a wrap bit.
- Sits directly above the gate/flop cell library: consumes that library's mux/demux/loadable-flop style of storage and provides the enqueue/dequeue queue stage the rest of the design talks to.
- Ready/valid handshake on both sides; storage is a register file, not a RAM macro.

Parameters:
- WIDTH, 8, data bits per entry (legal range 1..32).
- DEPTH, 8, number of entries. Fixed to 8 because the pointers are 3 bits; any other value is illegal and trips an elaboration check.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of queue contents (pointers only).
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  queue can accept; equals !full.
- in_data  input  WIDTH  enqueue data.
- out_valid  output  1  queue holds data; equals !empty.
- out_ready  input  1  consumer takes out_data.
- out_data  output  WIDTH  head entry, mem[rd_ptr[2:0]].
- full  output  1  8 entries held.
- empty  output  1  0 entries held.

Behaviour:
- Clocking and reset: one clock domain. reset is asynchronous and active-high. While reset is asserted, wr_ptr=rd_ptr=4'b0000 immediately, not on the next clock.
- Outputs during reset: empty=1, full=0, in_ready=1, out_valid=0. out_data is don't-care because memory is not reset.
- Pointers: wr_ptr and rd_ptr are 4 bits; bit 3 is the wrap bit and bits 2:0 are the index. Increment is modulo 16, so the index wraps 7 to 0 and toggles the wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (wr_ptr[2:0] == rd_ptr[2:0]) and (wr_ptr[3] != rd_ptr[3]).
- Enqueue fires when in_valid and in_ready at a clock edge. mem[wr_ptr[2:0]] <= in_data and wr_ptr increments.
- Dequeue fires when out_valid and out_ready at a clock edge. rd_ptr increments. out_data is a combinational read of the head entry.
- Latency: data enqueued at edge N is visible on out_valid/out_data after edge N. No same-cycle bypass from empty.
- Simultaneous enqueue and dequeue (neither full nor empty): both fire and the occupancy is unchanged.
- Full: in_ready=0, even if out_ready=1 in the same cycle, so there is no pass-through. The dequeue still fires; in_ready rises the next cycle.
- Empty: out_valid=0. An out_ready assertion is ignored and pointers do not move.
- Handshake: in_valid and in_data may change freely while in_ready=0. Once out_valid=1, out_data is stable until a dequeue fires.
- flush: at the clock edge, rd_ptr <= wr_ptr. Flush has priority over dequeue. An enqueue in the same cycle is dropped, because in_ready is forced to 0 while flush=1.
- Reset mid-operation: all queued data is lost. After reset release the queue behaves as freshly empty.

Optional Feature:
- Macro: QUEUE8_ERR_EN.
- When defined, adds two outputs:
  - err_ovf: output, 1 bit. Sticky; set when in_valid=1 while full=1.
  - err_udf: output, 1 bit. Sticky; set when out_ready=1 while empty=1.
- Both flags are cleared only by reset; flush leaves them unchanged. Their reset value is 0.
- When not defined, neither port exists and the pointer/data behaviour is identical to the enabled build.

Decomposition:
- Package queue8_pkg holds:
  - QUEUE_DEPTH = 8.
  - PTR_W = 3.
  - the typedef for the 4-bit wrap pointer (wrap bit plus 3-bit index).
- One natural sub-module: queue8_ptr. It is a 4-bit wrapping pointer register with async reset, synchronous load (used for flush) and increment enable. It is instantiated twice, once as the write pointer and once as the read pointer.
- Full/empty comparison and the storage array stay in queue8_ctrl.

Test Plan:
- Reset then idle -> empty=1, full=0, in_ready=1, out_valid=0; assert reset mid-stream and check the outputs return to these values before the next clock edge.
- Enqueue 0x11..0x88 over 8 cycles with out_ready=0 -> full=1 and in_ready=0 after the 8th edge; a 9th in_valid with 0x99 is dropped. With QUEUE8_ERR_EN defined, err_ovf=1.
- Drain the full queue with out_ready=1 -> out_data sequence 0x11..0x88, one per cycle; empty=1 after the 8th edge.
- Wrap-around: enqueue 5 entries, dequeue 5 entries, then enqueue 6 entries -> pointers wrap past index 7, and the 6 entries drain in order with no corruption.
- Simultaneous enqueue/dequeue at occupancy 3 for 10 cycles with incrementing data -> occupancy stays 3 and output order is preserved. At full with out_ready=1 and in_valid=1: only the dequeue fires, and in_ready rises the next cycle.
- Flush at occupancy 4 with in_valid=1 -> in_ready=0 that cycle, empty=1 next cycle, and the offered data never appears. out_ready on the empty queue -> no pointer movement. With QUEUE8_ERR_EN defined, err_udf=1 and it survives a flush.

Source files
------------

// File: rtl/queue8_pkg.sv
// Shared sizes and the wrap-pointer type for the 8-entry queue stage.
// The pointer is a wrap bit plus a 3-bit index, so full and empty are distinguishable.
package queue8_pkg;

   localparam int QUEUE_DEPTH = 8;
   localparam int PTR_W       = 3;

   typedef struct packed {
      logic             wrap;
      logic [PTR_W-1:0] idx;
   } qptr_t;

   // Modulo-16 increment: index 7 rolls to 0 and toggles the wrap bit.
   function automatic qptr_t qptr_inc(input qptr_t p);
      logic [PTR_W:0] flat;
      flat = p;
      flat = flat + 1'b1;
      return qptr_t'(flat);
   endfunction

endpackage

// File: rtl/queue8_ptr.sv
// 4-bit wrapping pointer register: async reset, synchronous load, increment enable.
// Load has priority over increment; the register updates one cycle after the request.
module queue8_ptr
   import queue8_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  load,
   input  qptr_t load_val,
   input  logic  inc,
   output qptr_t ptr
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= load_val;
      end else if (inc) begin
         ptr <= qptr_inc(ptr);
      end
   end

endmodule

// File: rtl/queue8_ctrl.sv
// 8-entry register-file FIFO, ready/valid both sides; enqueue visible one edge later, no bypass.
// in_ready=!full (and low during flush); optional sticky error flags under QUEUE8_ERR_EN.
module queue8_ctrl
   import queue8_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             full,
`ifdef QUEUE8_ERR_EN
   output logic             empty,
   output logic             err_ovf,
   output logic             err_udf
`else
   output logic             empty
`endif
);

   if (DEPTH != QUEUE_DEPTH) begin : g_bad_depth
      $error("queue8_ctrl: DEPTH must be 8 (3-bit pointers)");
   end
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("queue8_ctrl: WIDTH must be in 1..32");
   end

   qptr_t            wr_ptr;
   qptr_t            rd_ptr;
   logic             enq;
   logic             deq;
   logic [WIDTH-1:0] mem [QUEUE_DEPTH];

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr.idx == rd_ptr.idx) && (wr_ptr.wrap != rd_ptr.wrap);
   // Flush blocks the producer so a same-cycle enqueue cannot survive the pointer snap.
   assign in_ready  = !full && !flush;
   assign out_valid = !empty;
   assign out_data  = mem[rd_ptr.idx];

   assign enq = in_valid && in_ready;
   assign deq = out_valid && out_ready && !flush;

   queue8_ptr u_wr_ptr (
      .clk      (clk),
      .reset    (reset),
      .load     (1'b0),
      .load_val ('0),
      .inc      (enq),
      .ptr      (wr_ptr)
   );

   queue8_ptr u_rd_ptr (
      .clk      (clk),
      .reset    (reset),
      .load     (flush),
      .load_val (wr_ptr),
      .inc      (deq),
      .ptr      (rd_ptr)
   );

   // Storage is deliberately not reset; out_data is meaningless while empty.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr.idx] <= in_data;
      end
   end

`ifdef QUEUE8_ERR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (in_valid && full) begin
            err_ovf <= 1'b1;
         end
         if (out_ready && empty) begin
            err_udf <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_queue8_ctrl.sv
// Randomized and directed bench for queue8_ctrl against a queue-based reference model.
module tb_queue8_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       full;
   logic       empty;
`ifdef QUEUE8_ERR_EN
   logic       err_ovf;
   logic       err_udf;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] mq[$];
   logic       m_ovf;
   logic       m_udf;
   logic       m_enq;
   logic       m_deq;

   always #5 clk = ~clk;

   queue8_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .full      (full),
`ifdef QUEUE8_ERR_EN
      .empty     (empty),
      .err_ovf   (err_ovf),
      .err_udf   (err_udf)
`else
      .empty     (empty)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of entries plus the two sticky flags.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (in_valid && mq.size() == 8) m_ovf = 1'b1;
         if (out_ready && mq.size() == 0) m_udf = 1'b1;
         m_enq = in_valid && !flush && mq.size() < 8;
         m_deq = out_ready && !flush && mq.size() > 0;
         if (flush) begin
            mq.delete();
         end else begin
            if (m_deq) void'(mq.pop_front());
            if (m_enq) mq.push_back(in_data);
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("empty",     empty,     mq.size() == 0);
      chk("full",      full,      mq.size() == 8);
      chk("in_ready",  in_ready,  mq.size() < 8 && !flush);
      chk("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
`ifdef QUEUE8_ERR_EN
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_udf", err_udf, m_udf);
`endif
   end

   task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_empty"},     empty,     1'b1);
      chk({tag, "_full"},      full,      1'b0);
      chk({tag, "_in_ready"},  in_ready,  1'b1);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #2;
      chk_idle("rst");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(0, 8'h00, 0, 0);
      chk_idle("idle");

      // Fill 0x11..0x88, then an overflow attempt with 0x99.
      for (int i = 1; i <= 8; i++) cyc(1, 8'(8'h11 * i), 0, 0);
      chk("fill_full", full, 1'b1);
      chk("fill_in_ready", in_ready, 1'b0);
      cyc(1, 8'h99, 0, 0);
`ifdef QUEUE8_ERR_EN
      chk("ovf_set", err_ovf, 1'b1);
`endif

      // Drain in order.
      for (int i = 1; i <= 8; i++) begin
         chk("drain_data", out_data, 8'(8'h11 * i));
         cyc(0, 8'h00, 1, 0);
      end
      chk("drain_empty", empty, 1'b1);

      // Wrap-around: 5 in, 5 out, 6 in, 6 out.
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'hA0 + i), 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0);
      for (int i = 0; i < 6; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
      for (int i = 0; i < 6; i++) begin
         chk("wrap_data", out_data, 8'(8'hC0 + i));
         cyc(0, 8'h00, 1, 0);
      end

      // Simultaneous enqueue/dequeue at occupancy 3.
      for (int i = 0; i < 3; i++) cyc(1, 8'(i), 0, 0);
      for (int i = 3; i < 13; i++) begin
         chk("simul_data", out_data, 8'(i - 3));
         cyc(1, 8'(i), 1, 0);
      end
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);
      chk("simul_empty", empty, 1'b1);

      // Full with both sides active: only the dequeue fires.
      for (int i = 0; i < 8; i++) cyc(1, 8'(8'h30 + i), 0, 0);
      cyc(1, 8'hAB, 1, 0);
      chk("full_deq_in_ready", in_ready, 1'b1);
      chk("full_deq_head", out_data, 8'h31);
      for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0);

      // Flush at occupancy 4 with an offered entry.
      for (int i = 0; i < 4; i++) cyc(1, 8'(8'h50 + i), 0, 0);
      in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1; flush = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush_empty", empty, 1'b1);
      cyc(0, 8'h00, 1, 0);
      chk("udf_no_move", out_valid, 1'b0);
      cyc(0, 8'h00, 0, 1);
`ifdef QUEUE8_ERR_EN
      chk("udf_after_flush", err_udf, 1'b1);
`endif

      // Randomized traffic.
      for (int i = 0; i < 600; i++)
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 15) == 0));

      // Mid-stream reset: outputs must go idle before the next edge.
      for (int i = 0; i < 3; i++) cyc(1, 8'(8'h70 + i), 0, 0);
      reset = 1'b1;
      #1;
      chk_idle("midrst");
`ifdef QUEUE8_ERR_EN
      chk("midrst_ovf", err_ovf, 1'b0);
      chk("midrst_udf", err_udf, 1'b0);
`endif
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(0, 8'h00, 0, 0);
      chk_idle("postrst");
      cyc(1, 8'h42, 0, 0);
      chk("postrst_data", out_data, 8'h42);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
